// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter slice.
// Holds the FSM state encoding, the grant-owner encoding and the default bus widths.
// Imported by mem_arbiter and arb_watchdog.
package mem_arbiter_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog: cycle counter that flags when an outstanding device operation overruns.
// Latency: expired is registered-count compare, valid the cycle the count equals limit.
// Backpressure: none; counting stops at the limit until cleared.
// Ports: clk, rst (sync, active-high), clear (zero the count), enable (count this cycle),
//        limit (terminal count), expired (count has reached limit).
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] r_cnt;

  assign expired = (r_cnt == limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (MEM over IF) arbiter onto a single start/done device port.
// Latency: grant -> ISSUE next cycle; ack one cycle after dev_done rises in WAIT.
// Backpressure: stall held while a requester waits for its ack; one op in flight at a time.
// Ports: clk/rst (sync, active-high); if_* fetch port (read only); mem_* data port;
//        stall pipeline freeze; dev_* device port driven from latched grant fields;
//        err sticky timeout flag.
// Optional feature: define ARB_TIMEOUT_EN to build the arb_watchdog timeout (limit TMO);
// otherwise err is tied low and the FSM waits for dev_done indefinitely.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int TMO = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_ack,
  output logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          dev_start,
  output logic          dev_rd,
  output logic          dev_wr,
  output logic [AW-1:0] dev_addr,
  output logic [DW-1:0] dev_wdata,
  input  logic          dev_done,
  input  logic [DW-1:0] dev_result,
  output logic          err
);

  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_owner;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_rd;
  logic          r_wr;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_mem_rdata;

  logic          w_grant;    // IDLE -> ISSUE: capture the winning request
  logic          w_fin;      // WAIT -> RESP on dev_done
  logic          w_tmo_hit;  // ISSUE/WAIT -> RESP on watchdog expiry
  logic          w_expired;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic r_err;

  arb_watchdog #(.CW(CW)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_grant),
    .enable  ((r_state == ST_ISSUE) || (r_state == ST_WAIT)),
    .limit   (CW'(TMO)),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_tmo_hit) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TMO != 0);
  assign w_expired    = 1'b0;
  assign err          = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_fin       = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req || if_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_expired) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (!dev_done) begin
          // Device has accepted the start once its done flag drops.
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dev_done) begin
          w_fin       = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_expired) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        if (mem_req) begin
          r_owner <= OWN_MEM;
          r_addr  <= mem_addr;
          r_wdata <= mem_wdata;
          r_rd    <= ~mem_wr;
          r_wr    <= mem_wr;
        end else begin
          r_owner <= OWN_IF;
          r_addr  <= if_addr;
          r_wdata <= '0;
          r_rd    <= 1'b1;
          r_wr    <= 1'b0;
        end
      end
      // Result lands on the edge into RESP so rdata is valid alongside the ack.
      if (w_fin && r_rd) begin
        if (r_owner == OWN_MEM) r_mem_rdata <= dev_result;
        else                    r_if_rdata  <= dev_result;
      end
      if (w_tmo_hit) begin
        if (r_owner == OWN_MEM) r_mem_rdata <= '1;
        else                    r_if_rdata  <= '1;
      end
    end
  end

  assign if_ack    = (r_state == ST_RESP) && (r_owner == OWN_IF);
  assign mem_ack   = (r_state == ST_RESP) && (r_owner == OWN_MEM);
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign dev_start = (r_state == ST_ISSUE);
  assign dev_rd    = r_rd;
  assign dev_wr    = r_wr;
  assign dev_addr  = r_addr;
  assign dev_wdata = r_wdata;
  assign stall     = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drives on the falling edge, checks on the falling edge
// after each rising edge, with hand-computed expected values.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          mem_req = 1'b0;
  logic          mem_wr = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall;
  logic          dev_start;
  logic          dev_rd;
  logic          dev_wr;
  logic [AW-1:0] dev_addr;
  logic [DW-1:0] dev_wdata;
  logic          dev_done = 1'b1;
  logic [DW-1:0] dev_result = '0;
  logic          err;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .TMO(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .dev_start  (dev_start),
    .dev_rd     (dev_rd),
    .dev_wr     (dev_wr),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_done   (dev_done),
    .dev_result (dev_result),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_ack"},    if_ack,    0);
    chk({tag, "_mem_ack"},   mem_ack,   0);
    chk({tag, "_dev_start"}, dev_start, 0);
    chk({tag, "_dev_rd"},    dev_rd,    0);
    chk({tag, "_dev_wr"},    dev_wr,    0);
    chk({tag, "_dev_addr"},  dev_addr,  0);
    chk({tag, "_dev_wdata"}, dev_wdata, 0);
    chk({tag, "_if_rdata"},  if_rdata,  0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_err"},       err,       0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit got_ack;

    // ---- reset state ----
    nx(); nx();
    chk_reset_outputs("rst");
    chk("rst_stall", stall, 0);
    rst = 1'b0;

    // ---- single IF read ----
    if_req = 1'b1; if_addr = 16'h0040;
    #1 chk("if1_stall_req", stall, 1);
    nx();                                   // ISSUE
    chk("if1_start", dev_start, 1);
    chk("if1_rd", dev_rd, 1);
    chk("if1_wr", dev_wr, 0);
    chk("if1_addr", dev_addr, 16'h0040);
    dev_done = 1'b0;
    nx();                                   // WAIT
    chk("if1_start_wait", dev_start, 0);
    chk("if1_noack_wait", if_ack, 0);
    nx(); nx();                             // still WAIT
    chk("if1_noack_wait2", if_ack, 0);
    dev_done = 1'b1; dev_result = 16'h1234;
    nx();                                   // RESP
    chk("if1_ack", if_ack, 1);
    chk("if1_mem_ack", mem_ack, 0);
    chk("if1_rdata", if_rdata, 16'h1234);
    chk("if1_stall_ack", stall, 0);
    if_req = 1'b0;
    nx();                                   // IDLE
    chk("if1_ack_one_cycle", if_ack, 0);
    chk("if1_rdata_hold", if_rdata, 16'h1234);

    // ---- simultaneous MEM write + IF read ----
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'hBF00; mem_wdata = 16'h0041;
    if_req = 1'b1; if_addr = 16'h0041;
    #1 chk("sim_stall_req", stall, 1);
    nx();                                   // ISSUE (MEM)
    chk("sim_start_mem", dev_start, 1);
    chk("sim_wr", dev_wr, 1);
    chk("sim_rd", dev_rd, 0);
    chk("sim_addr_mem", dev_addr, 16'hBF00);
    chk("sim_wdata", dev_wdata, 16'h0041);
    dev_done = 1'b0;
    nx();                                   // WAIT
    dev_done = 1'b1; dev_result = 16'hDEAD;
    nx();                                   // RESP (MEM)
    chk("sim_mem_ack", mem_ack, 1);
    chk("sim_if_ack_early", if_ack, 0);
    chk("sim_mem_rdata_write", mem_rdata, 0);
    chk("sim_stall_if_pending", stall, 1);
    mem_req = 1'b0; mem_wr = 1'b0;
    nx();                                   // IDLE
    chk("sim_mem_ack_one", mem_ack, 0);
    chk("sim_stall_idle", stall, 1);
    chk("sim_no_start_idle", dev_start, 0);
    nx();                                   // ISSUE (IF)
    chk("sim_start_if", dev_start, 1);
    chk("sim_if_rd", dev_rd, 1);
    chk("sim_if_wr", dev_wr, 0);
    chk("sim_addr_if", dev_addr, 16'h0041);
    dev_done = 1'b0;
    nx();                                   // WAIT
    dev_done = 1'b1; dev_result = 16'h5A5A;
    nx();                                   // RESP (IF)
    chk("sim_if_ack", if_ack, 1);
    chk("sim_if_rdata", if_rdata, 16'h5A5A);
    chk("sim_mem_rdata_keep", mem_rdata, 0);
    chk("sim_stall_done", stall, 0);
    if_req = 1'b0;
    nx();                                   // IDLE

    // ---- back-to-back MEM reads ----
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 16'h8000;
    nx();                                   // ISSUE
    chk("b2b1_start", dev_start, 1);
    chk("b2b1_rd", dev_rd, 1);
    chk("b2b1_addr", dev_addr, 16'h8000);
    nx();                                   // still ISSUE, done high
    chk("b2b1_start_hold", dev_start, 1);
    dev_done = 1'b0;
    nx();                                   // WAIT
    chk("b2b1_wait", dev_start, 0);
    dev_done = 1'b1; dev_result = 16'h1111;
    nx();                                   // RESP
    chk("b2b1_ack", mem_ack, 1);
    chk("b2b1_rdata", mem_rdata, 16'h1111);
    mem_addr = 16'h8001;
    nx();                                   // IDLE
    chk("b2b_gap_ack", mem_ack, 0);
    chk("b2b_gap_start", dev_start, 0);
    chk("b2b_gap_rdata", mem_rdata, 16'h1111);
    nx();                                   // ISSUE
    chk("b2b2_start", dev_start, 1);
    chk("b2b2_addr", dev_addr, 16'h8001);
    dev_done = 1'b0;
    nx();                                   // WAIT
    chk("b2b2_wait", dev_start, 0);
    dev_done = 1'b1; dev_result = 16'h2222;
    nx();                                   // RESP
    chk("b2b2_ack", mem_ack, 1);
    chk("b2b2_rdata", mem_rdata, 16'h2222);
    chk("b2b2_if_rdata_hold", if_rdata, 16'h5A5A);
    mem_req = 1'b0;
    nx();                                   // IDLE

    // ---- reset during WAIT ----
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'h1234; mem_wdata = 16'hBEEF;
    nx();                                   // ISSUE
    dev_done = 1'b0;
    nx();                                   // WAIT
    chk("rw_wait_start", dev_start, 0);
    chk("rw_wait_wr", dev_wr, 1);
    rst = 1'b1;
    nx();                                   // reset applied
    chk_reset_outputs("rw");
    chk("rw_stall_comb", stall, 1);
    rst = 1'b0; mem_req = 1'b0; mem_wr = 1'b0; dev_done = 1'b1;
    nx();
    chk("rw_no_ack_after", mem_ack, 0);
    chk("rw_idle_no_start", dev_start, 0);

    // ---- dev_done already low at grant: one ISSUE cycle ----
    dev_done = 1'b0; if_req = 1'b1; if_addr = 16'h0077;
    nx();                                   // ISSUE
    chk("pre_issue_start", dev_start, 1);
    chk("pre_issue_addr", dev_addr, 16'h0077);
    nx();                                   // WAIT after a single ISSUE cycle
    chk("pre_wait_start", dev_start, 0);

`ifdef ARB_TIMEOUT_EN
    // dev_done held low: the watchdog must end the operation.
    got_ack = 1'b0;
    for (int i = 0; i < 20 && !got_ack; i++) begin
      nx();
      if (if_ack) got_ack = 1'b1;
    end
    chk("tmo_ack_seen", got_ack, 1);
    chk("tmo_rdata", if_rdata, 16'hFFFF);
    chk("tmo_err", err, 1);
    if_req = 1'b0;
    nx();
    chk("tmo_err_sticky", err, 1);
`else
    // dev_done held low: no watchdog, the FSM waits indefinitely.
    got_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nx();
      if (if_ack || dev_start || err) got_ack = 1'b1;
    end
    chk("hold_no_ack_no_err", got_ack, 0);
    chk("hold_err", err, 0);
    chk("hold_stall", stall, 1);
    dev_done = 1'b1; dev_result = 16'h0F0F;
    nx();                                   // RESP
    chk("hold_final_ack", if_ack, 1);
    chk("hold_final_rdata", if_rdata, 16'h0F0F);
    if_req = 1'b0;
    nx();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, width of all address ports.
REQ-002 Parameter DW, default 16, width of all data ports.
REQ-003 Parameter TMO, default 1023, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.
REQ-004 The clocking and reset decision SHALL be exactly: one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be, in order (name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DW  fetch data.
- mem_req  in  1  data-stage request.
- mem_wr  in  1  1 = write, 0 = read.
- mem_addr  in  AW  data address.
- mem_wdata  in  DW  write data.
- mem_ack  out  1  one-cycle data completion pulse.
- mem_rdata  out  DW  read data.
- stall  out  1  pipeline freeze.
- dev_start  out  1  start to memory/UART port.
- dev_rd  out  1  port read.
- dev_wr  out  1  port write.
- dev_addr  out  AW  port address.
- dev_wdata  out  DW  port write data.
- dev_done  in  1  level done flag: drops when an operation starts, stays high after it completes.
- dev_result  in  DW  port read result.
- err  out  1  sticky timeout flag.

Function
REQ-006 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-007 IDLE: if mem_req=1, grant MEM; otherwise if if_req=1, grant IF; then go to ISSUE. MEM has fixed priority.
REQ-008 Grant capture: on the IDLE->ISSUE edge, latch the grant owner, addr, wdata and rd/wr; dev_* SHALL drive only latched values.
REQ-009 IF grants SHALL always be reads.
REQ-010 ISSUE: assert dev_start=1; go to WAIT on the first cycle dev_done=0.
REQ-011 WAIT: dev_start=0; on the first cycle dev_done=1, latch dev_result (reads only) and go to RESP.
REQ-012 RESP: pulse the owner's ack for exactly one cycle with rdata valid; return to IDLE.
REQ-013 The next grant SHALL be evaluated no earlier than the cycle after RESP.
REQ-014 rdata outputs SHALL hold their last value until the next ack to that owner.
REQ-015 stall SHALL be combinational: (if_req & ~if_ack) | (mem_req & ~mem_ack).
REQ-016 Simultaneous requests: serve MEM first; keep IF pending, then serve it after MEM's RESP if if_req is still high.
REQ-017 A requester SHALL hold req and its fields stable until its ack. Deassertion before ack is not supported; the latched operation completes regardless.
REQ-018 mem_wr=1: mem_rdata SHALL be unchanged and mem_ack SHALL still pulse.
REQ-019 dev_done already 0 on entry to ISSUE SHALL advance to WAIT after a single ISSUE cycle.

Reset
REQ-020 With rst=1 at a clk edge: state=IDLE, all acks=0, dev_start=dev_rd=dev_wr=0, dev_addr=dev_wdata=0, if_rdata=mem_rdata=0, err=0, watchdog=0.
REQ-021 Reset mid-operation SHALL abandon the transaction with no ack issued; the device itself is not reset by this block.

Configuration
REQ-022 With macro ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to ISSUE and increment in ISSUE and WAIT.
REQ-023 When that counter reaches TMO: set err=1, pulse the owner's ack with rdata=all-ones, and return to IDLE.
REQ-024 Without ARB_TIMEOUT_EN: no counter is built, err SHALL be tied to 0, and the FSM waits indefinitely.

Structure
REQ-025 A shared package SHALL hold the state encoding constants, the owner encoding (OWN_IF, OWN_MEM) and the default AW/DW values.
REQ-026 The watchdog SHALL be a sub-module arb_watchdog (clear, enable, limit, expired), instantiated only under ARB_TIMEOUT_EN.
REQ-027 There SHALL be no other sub-modules.

Verification
REQ-028 Single IF read: if_req=1, if_addr=0x0040; device done drops after 1 cycle, rises 3 cycles later with result 0x1234 -> dev_rd=1, dev_addr=0x0040, one if_ack pulse, if_rdata=0x1234.
REQ-029 Simultaneous requests: MEM write (mem_addr=0xBF00, mem_wdata=0x0041) with IF read 0x0041 -> MEM write served first (dev_wr=1, dev_wdata=0x0041), mem_ack pulses; IF is served after; stall=1 until if_ack.
REQ-030 Back-to-back MEM reads of 0x8000 then 0x8001 -> two separate ISSUE phases, each waits for dev_done to fall, rdata values in order.
REQ-031 Reset asserted during WAIT -> next cycle state=IDLE, no ack pulses, all outputs at reset values.
REQ-032 ARB_TIMEOUT_EN with TMO=8 and dev_done held at 0 -> err=1 after 8 cycles, ack pulses with rdata=0xFFFF; without the macro the FSM stays in WAIT and err=0.
REQ-033 dev_done already 0 on grant -> exactly one ISSUE cycle, then WAIT.
